xeng_postproc: RTL

- Inverse of the X-engine pre-processor.
- Takes the staggered, offset-binary (uint) dual-pol sample bus and re-aligns the P_FACTOR parallel lanes (de-stagger).
- Converts each real/imag component back to two's complement.
- Delays sync to match, and monitors sync periodicity against the serial accumulation length.
- Sits at the tap/debug output of the X-engine DSP chain and feeds the loop-back checker and the capture path.

---
 rtl/xeng_postproc_pkg.sv | 35 +++
 rtl/xeng_destagger_lane.sv | 43 ++++
 rtl/xeng_postproc.sv | 121 ++++++++++++
 3 files changed

// File: rtl/xeng_postproc_pkg.sv
// Shared layout helpers for the X-engine pre/post-processors: lane geometry,
// stagger depths and bit-slice positions of the dual-pol sample bus.
package xeng_postproc_pkg;

  typedef enum logic {
    MON_IDLE = 1'b0,
    MON_RUN  = 1'b1
  } mon_state_t;

  function automatic int p_factor(int pf_bits);
    return 1 << pf_bits;
  endfunction

  function automatic int input_width(int pf_bits, int bitwidth);
    return 2 * bitwidth * 2 * p_factor(pf_bits);
  endfunction

  // A single lane has nothing to stagger against, so the offset does not apply.
  function automatic int max_delay(int pf_bits, int stagger_offset);
    return (pf_bits == 0) ? 0 : (p_factor(pf_bits) - 1 + stagger_offset);
  endfunction

  function automatic int latency(int pf_bits, int stagger_offset);
    return max_delay(pf_bits, stagger_offset) + 1;
  endfunction

  function automatic int lane_delay(int lane, int stagger_offset);
    return lane + ((lane > 0) ? stagger_offset : 0);
  endfunction

  function automatic int lane_lsb(int pol, int lane, int pf_bits, int bitwidth);
    return pol * 2 * bitwidth * p_factor(pf_bits) + lane * 2 * bitwidth;
  endfunction

endpackage

// File: rtl/xeng_destagger_lane.sv
// One complex lane: DEPTH-cycle free-running delay, then a registered
// offset-binary to two's-complement conversion (MSB flip on real and imag).
module xeng_destagger_lane #(
  parameter int DEPTH    = 0,
  parameter int BITWIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*BITWIDTH-1:0]   din,
  output logic [2*BITWIDTH-1:0]   dout
);

  localparam int W = 2 * BITWIDTH;
  localparam logic [W-1:0] MSB_MASK =
    {1'b1, {(BITWIDTH-1){1'b0}}, 1'b1, {(BITWIDTH-1){1'b0}}};

  logic [W-1:0] tap;

  generate
    if (DEPTH == 0) begin : g_nodly
      assign tap = din;
    end else begin : g_dly
      logic [W-1:0] sr [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
          sr[0] <= din;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end

      assign tap = sr[DEPTH-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout <= '0;
    else     dout <= tap ^ MSB_MASK;
  end

endmodule

// File: rtl/xeng_postproc.sv
// X-engine post-processor: de-staggers the parallel lanes, converts uint to
// two's complement, delays valid/sync to match and monitors sync periodicity.
module xeng_postproc
  import xeng_postproc_pkg::*;
#(
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int P_FACTOR_BITS       = 2,
  parameter int BITWIDTH            = 4,
  parameter int STAGGER_OFFSET      = 0,
  localparam int INPUT_WIDTH        = input_width(P_FACTOR_BITS, BITWIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sync,
  input  logic                   din_valid,
  input  logic [INPUT_WIDTH-1:0] din,
  output logic [INPUT_WIDTH-1:0] dout,
  output logic                   dout_valid,
  output logic                   sync_out,
  output logic                   locked,
  output logic                   sync_err
);

  localparam int P_FACTOR = p_factor(P_FACTOR_BITS);
  localparam int MAXD     = max_delay(P_FACTOR_BITS, STAGGER_OFFSET);
  localparam int L        = latency(P_FACTOR_BITS, STAGGER_OFFSET);
  localparam int LW       = 2 * BITWIDTH;
  localparam int PW       = $clog2(L + 1);
  localparam int CW       = SERIAL_ACC_LEN_BITS;
  localparam logic [CW-1:0] CNT_MAX = '1;

  // Lane k arrived d_k late, so it waits MAXD-d_k here to line up with lane 0.
  for (genvar p = 0; p < 2; p++) begin : g_pol
    for (genvar k = 0; k < P_FACTOR; k++) begin : g_lane
      localparam int LSB = lane_lsb(p, k, P_FACTOR_BITS, BITWIDTH);

      xeng_destagger_lane #(
        .DEPTH    (MAXD - lane_delay(k, STAGGER_OFFSET)),
        .BITWIDTH (BITWIDTH)
      ) u_lane (
        .clk  (clk),
        .rst  (rst),
        .din  (din[LSB +: LW]),
        .dout (dout[LSB +: LW])
      );
    end
  end

  logic [L-1:0]  vld_sr;
  logic [L-1:0]  sync_sr;
  logic [PW-1:0] prime_cnt;
  logic          primed;

  assign primed = (prime_cnt == PW'(L));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr    <= '0;
      sync_sr   <= '0;
      prime_cnt <= '0;
    end else begin
      vld_sr  <= (vld_sr << 1) | L'(din_valid);
      sync_sr <= (sync_sr << 1) | L'(sync);
      if (!primed) prime_cnt <= prime_cnt + PW'(1);
    end
  end

  assign dout_valid = vld_sr[L-1] & primed;
  assign sync_out   = sync_sr[L-1] & primed;

  mon_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          locked_nxt, sync_err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MON_IDLE;
      cnt      <= '0;
      locked   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      locked   <= locked_nxt;
      sync_err <= sync_err_nxt;
    end
  end

  // A sync is only legal on the last count of the period; anything else, or
  // a missing sync at the wrap, is a sticky error and realigns the counter.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    locked_nxt   = locked;
    sync_err_nxt = sync_err;
    case (state)
      MON_IDLE: begin
        if (sync) begin
          state_nxt = MON_RUN;
          cnt_nxt   = '0;
        end
      end
      MON_RUN: begin
        cnt_nxt = cnt + CW'(1);
        if (sync) begin
          cnt_nxt = '0;
          if (cnt == CNT_MAX) begin
            locked_nxt = 1'b1;
          end else begin
            sync_err_nxt = 1'b1;
            locked_nxt   = 1'b0;
          end
        end else if (cnt == CNT_MAX) begin
          sync_err_nxt = 1'b1;
          locked_nxt   = 1'b0;
        end
      end
    endcase
  end

endmodule
